// File: rtl/obi_wb_pkg.sv
// Shared definitions for the OBI-to-Wishbone window bridge.
//   state_e       : bridge FSM states
//   DEF_WIN_SEL   : default select codes, index 0 in the LSBs
//   DEF_WIN_BASE  : default translated Wishbone bases, index 0 in the LSBs
//   idx_width()   : width of a window index for n windows (never below 1)
package obi_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [15:0] DEF_WIN_SEL  = {8'h0F, 8'h0E};
    localparam logic [63:0] DEF_WIN_BASE = {32'h0000_2000, 32'h0000_4000};

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/obi_wb_win_bridge_if.sv
// Bus bundles for the window bridge.
//   obi_if : OBI request/response channel. The slave modport is the bridge side.
//   wb_if  : classic Wishbone channel. The master modport is the bridge side.
//            dat_w carries master-to-slave data, dat_r slave-to-master data.
interface obi_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

interface wb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]     adr;
    logic [DATA_W-1:0]     dat_w;
    logic [DATA_W-1:0]     dat_r;
    logic                  we;
    logic [DATA_W/8-1:0]   sel;
    logic                  cyc;
    logic                  stb;
    logic                  ack;
    logic                  err;

    modport master (output adr, dat_w, we, sel, cyc, stb, input dat_r, ack, err);
    modport slave  (input adr, dat_w, we, sel, cyc, stb, output dat_r, ack, err);
endinterface

// File: rtl/obi_wb_win_decode.sv
// Combinational window decoder.
//   addr_i : incoming OBI address
//   hit_o  : select field matches one of the windows
//   idx_o  : matching window index (lowest index wins)
//   xadr_o : WIN_BASE[idx] OR'd with the address, select field cleared
module obi_wb_win_decode
    import obi_wb_pkg::*;
#(
    parameter int                          ADDR_W   = 32,
    parameter int                          NUM_WIN  = 2,
    parameter int                          SEL_W    = 8,
    parameter logic [NUM_WIN*SEL_W-1:0]    WIN_SEL  = DEF_WIN_SEL,
    parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_BASE = DEF_WIN_BASE,
    localparam int                         IDX_W    = idx_width(NUM_WIN)
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [ADDR_W-1:0] xadr_o
);

    localparam logic [ADDR_W-1:0] SEL_MASK = {{SEL_W{1'b1}}, {(ADDR_W-SEL_W){1'b0}}};

    // Walk from the highest index down so the lowest match is the last write.
    always_comb begin
        hit_o  = 1'b0;
        idx_o  = '0;
        xadr_o = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (addr_i[ADDR_W-1 -: SEL_W] == WIN_SEL[i*SEL_W +: SEL_W]) begin
                hit_o  = 1'b1;
                idx_o  = IDX_W'(i);
                xadr_o = WIN_BASE[i*ADDR_W +: ADDR_W] | (addr_i & ~SEL_MASK);
            end
        end
    end

endmodule

// File: rtl/obi_wb_win_bridge.sv
// OBI slave to Wishbone master bridge with address windows and a wait timeout.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   obi           : OBI slave side (one outstanding transaction)
//   wb            : Wishbone master side
//   tmo_o         : one-cycle pulse when a Wishbone transfer is aborted by timeout
//
// state   | meaning
// IDLE    | waiting for req; gnt follows req combinationally
// BUS     | Wishbone cycle active, waiting for ack/err or timeout
// RESP    | rvalid for one cycle, then back to IDLE
module obi_wb_win_bridge
    import obi_wb_pkg::*;
#(
    parameter int                          ADDR_W   = 32,
    parameter int                          DATA_W   = 32,
    parameter int                          NUM_WIN  = 2,
    parameter int                          SEL_W    = 8,
    parameter logic [NUM_WIN*SEL_W-1:0]    WIN_SEL  = DEF_WIN_SEL,
    parameter logic [NUM_WIN*ADDR_W-1:0]   WIN_BASE = DEF_WIN_BASE,
    parameter int                          TIMEOUT  = 255
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    obi_if.slave    obi,
    wb_if.master    wb,
    output logic    tmo_o
);

    localparam int                IDX_W    = idx_width(NUM_WIN);
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     adr_q, adr_d;
    logic [DATA_W-1:0]     dat_q, dat_d;
    logic                  we_q, we_d;
    logic [DATA_W/8-1:0]   sel_q, sel_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  tmo_q, tmo_d;

    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [ADDR_W-1:0]     dec_xadr;
    logic                  win_hit;

    obi_wb_win_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_WIN  (NUM_WIN),
        .SEL_W    (SEL_W),
        .WIN_SEL  (WIN_SEL),
        .WIN_BASE (WIN_BASE)
    ) u_decode (
        .addr_i (obi.addr),
        .hit_o  (dec_hit),
        .idx_o  (dec_idx),
        .xadr_o (dec_xadr)
    );

    // Index range guard keeps a non-power-of-two window count from aliasing.
    assign win_hit = dec_hit && (int'(dec_idx) < NUM_WIN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = 1'b0;
        obi.gnt = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                obi.gnt = obi.req;
                if (obi.req) begin
                    if (win_hit) begin
                        adr_d   = dec_xadr;
                        dat_d   = obi.wdata;
                        we_d    = obi.we;
                        sel_d   = obi.be;
                        cnt_d   = '0;
                        state_d = ST_BUS;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_BUS: begin
                // err beats ack, and either beats the timeout in the same cycle
                if (wb.err) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (wb.ack) begin
                    rdata_d = we_q ? '0 : wb.dat_r;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // cyc/stb decode straight from state so reset drops them without a clock.
    assign wb.cyc     = (state_q == ST_BUS);
    assign wb.stb     = (state_q == ST_BUS);
    assign wb.adr     = adr_q;
    assign wb.dat_w   = dat_q;
    assign wb.we      = we_q;
    assign wb.sel     = sel_q;
    assign obi.rvalid = (state_q == ST_RESP);
    assign obi.rdata  = rdata_q;
    assign obi.err    = err_q;
    assign tmo_o      = tmo_q;

endmodule

// File: tb/tb_obi_wb_win_bridge.sv
module tb_obi_wb_win_bridge;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    localparam int M_ACK    = 0;
    localparam int M_ERR    = 1;
    localparam int M_BOTH   = 2;
    localparam int M_SILENT = 3;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    logic tmo_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    always #5 clk_i = ~clk_i;

    obi_if #(.ADDR_W(AW), .DATA_W(DW)) obi ();
    wb_if  #(.ADDR_W(AW), .DATA_W(DW)) wb ();

    obi_wb_win_bridge #(.TIMEOUT(TMO)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .obi    (obi),
        .wb     (wb),
        .tmo_o  (tmo_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference window map: sel 0x0E -> 0x4000, sel 0x0F -> 0x2000.
    task automatic xlate(input logic [31:0] a, output logic hit, output logic [31:0] x);
        hit = 1'b1;
        if (a[31:24] == 8'h0E)      x = 32'h0000_4000 | {8'h00, a[23:0]};
        else if (a[31:24] == 8'h0F) x = 32'h0000_2000 | {8'h00, a[23:0]};
        else begin hit = 1'b0; x = '0; end
    endtask

    task automatic do_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input int waits, input int mode,
                          input logic [31:0] rd);
        logic        hit;
        logic [31:0] xadr;
        exp_t        e, got_e;
        int          cyc_cnt, tmo_cnt, exp_cyc;
        bit          got;
        xlate(addr, hit, xadr);
        e.err   = !hit || (mode != M_ACK);
        e.rdata = (e.err || we) ? 32'h0 : rd;
        e.lat   = !hit ? 1 : (mode == M_SILENT) ? TMO + 1 : waits + 2;
        exp_cyc = !hit ? 0 : (mode == M_SILENT) ? TMO : waits + 1;

        @(negedge clk_i);
        obi.req = 1'b1; obi.addr = addr; obi.we = we; obi.be = be; obi.wdata = wdata;
        wb.dat_r = rd;
        #1 check("gnt_idle", obi.gnt, 1);
        sb_q.push_back(e);
        @(posedge clk_i);
        #1 obi.addr = ~addr; obi.wdata = ~wdata; obi.be = ~be; obi.we = ~we;
        cyc_cnt = 0; tmo_cnt = 0; got = 0;
        for (int c = 1; c <= TMO + 8 && !got; c++) begin
            @(negedge clk_i);
            check("gnt_busy", obi.gnt, 0);
            if (wb.cyc) begin
                check("wb_adr", wb.adr, xadr);
                check("wb_stb", wb.stb, 1);
                if (cyc_cnt == 0) begin
                    check("wb_we", wb.we, we);
                    check("wb_sel", wb.sel, be);
                    check("wb_dat", wb.dat_w, wdata);
                end
                wb.ack = (mode == M_ACK || mode == M_BOTH) && cyc_cnt == waits;
                wb.err = (mode == M_ERR || mode == M_BOTH) && cyc_cnt == waits;
                cyc_cnt++;
            end else begin
                wb.ack = 1'b0; wb.err = 1'b0;
            end
            if (tmo_o) tmo_cnt++;
            if (obi.rvalid) begin
                got = 1;
                if (sb_q.size() == 0) check("sb_empty", 1, 0);
                else begin
                    got_e = sb_q.pop_front();
                    check("rdata", obi.rdata, got_e.rdata);
                    check("err", obi.err, got_e.err);
                    check("latency", c, got_e.lat);
                end
            end
        end
        if (!got) check("rvalid_seen", 0, 1);
        obi.req = 1'b0;
        @(negedge clk_i);
        check("rvalid_one_cycle", obi.rvalid, 0);
        check("cyc_cycles", cyc_cnt, exp_cyc);
        check("tmo_pulses", tmo_cnt, (hit && mode == M_SILENT) ? 1 : 0);
    endtask

    initial begin
        obi.req = 1'b0; obi.addr = '0; obi.we = 1'b0; obi.be = '0; obi.wdata = '0;
        wb.dat_r = '0; wb.ack = 1'b0; wb.err = 1'b0;
        #12;
        check("rst_cyc", wb.cyc, 0);
        check("rst_stb", wb.stb, 0);
        check("rst_rvalid", obi.rvalid, 0);
        check("rst_err", obi.err, 0);
        check("rst_tmo", tmo_o, 0);
        check("rst_adr", wb.adr, 0);
        check("rst_rdata", obi.rdata, 0);
        check("rst_we", wb.we, 0);
        @(negedge clk_i) rst_ni = 1'b1;

        do_txn(32'h0F00_0010, 1'b0, 4'hF, 32'h0,         2, M_ACK,    32'hCAFE_F00D);
        do_txn(32'h0E00_0004, 1'b1, 4'h3, 32'h1234_5678, 0, M_ACK,    32'hDEAD_BEEF);
        do_txn(32'h0100_0000, 1'b0, 4'hF, 32'h0,         0, M_ACK,    32'h5555_AAAA);
        do_txn(32'h0F00_0020, 1'b0, 4'hF, 32'h0,         0, M_SILENT, 32'h1111_2222);
        do_txn(32'h0E00_0100, 1'b0, 4'hF, 32'h0,         1, M_BOTH,   32'h3333_4444);
        do_txn(32'h0F00_00FC, 1'b1, 4'hC, 32'hA5A5_5A5A, 0, M_ERR,    32'h0);
        do_txn(32'h0E12_3458, 1'b0, 4'hF, 32'h0,         3, M_ACK,    32'h7777_8888);
        do_txn(32'h0F00_0000, 1'b0, 4'hF, 32'h0,         0, M_ACK,    32'h0BAD_F00D);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] a;
            a = $urandom;
            case ($urandom_range(0, 2))
                0: a[31:24] = 8'h0E;
                1: a[31:24] = 8'h0F;
                default: ;
            endcase
            do_txn(a, 1'($urandom_range(0, 1)), 4'($urandom), $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
        end

        // Reset while the Wishbone cycle is open.
        @(negedge clk_i);
        obi.req = 1'b1; obi.addr = 32'h0F00_0040; obi.we = 1'b0; obi.be = 4'hF;
        @(posedge clk_i);
        #1 obi.req = 1'b0;
        @(negedge clk_i);
        check("pre_rst_cyc", wb.cyc, 1);
        #2 rst_ni = 1'b0;
        #1 check("rst_cyc_async", wb.cyc, 0);
        check("rst_stb_async", wb.stb, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("rst_no_rvalid", obi.rvalid, 0);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("post_rst_no_rvalid", obi.rvalid, 0);
        do_txn(32'h0F00_0044, 1'b0, 4'hF, 32'h0, 1, M_ACK, 32'h600D_CAFE);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
